pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised program-counter unit for the RiSC-16 fetch stage.
- Drives the next-instruction address from four sources: sequential, PC-relative branch, ALU jump target, and a return pop.
- Contains a small circular return-address stack (RAS) for call/return, plus a stall input that freezes all state.
- Sits between the control decoder (pc_sel, push_ra, stall) and instruction memory (nxt_instr).

Parameters:
- PC_WIDTH, 16: address width in bits.
- IMM_WIDTH, 7: branch immediate width, two's complement.
- RAS_DEPTH, 4: return-address stack entries; power of two, at least 2.
- RESET_VECTOR, 0: PC value on reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  1 = hold PC and RAS unchanged this cycle.
- pc_sel  in  2  next-PC select: 00 seq, 01 branch, 10 jump, 11 return.
- imm  in  IMM_WIDTH  signed branch offset.
- alu_out  in  PC_WIDTH  jump target.
- push_ra  in  1  push PC+1 onto the RAS; honoured only with pc_sel=10.
- nxt_instr  out  PC_WIDTH  registered current PC (fetch address).
- ras_empty  out  1  RAS holds zero valid entries.
- ras_full  out  1  RAS holds RAS_DEPTH valid entries.
- ras_underflow  out  1  one-cycle pulse when a return finds the RAS empty.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous, active-low.
- While rst_n=0, immediately (no clock edge needed):
  - nxt_instr = RESET_VECTOR
  - RAS count = 0, top pointer = 0
  - ras_empty = 1, ras_full = 0, ras_underflow = 0
- RAS entry contents are don't-care after reset.
- Definitions: pc1 = nxt_instr + 1; sext(imm) = imm sign-extended to PC_WIDTH. All arithmetic is modulo 2^PC_WIDTH, so 0xFFFF + 1 = 0x0000 at width 16.
- Next PC at each rising edge, when stall=0:
  - 00: pc1.
  - 01: pc1 + sext(imm).
  - 10: alu_out. If push_ra=1, also push pc1.
  - 11, RAS non-empty: pop the top entry; it becomes nxt_instr.
  - 11, RAS empty: fall back to pc1 and pulse ras_underflow high for exactly the following cycle.
- Latency: one cycle. The selected value appears on nxt_instr after the edge at which it was sampled.
- Stall:
  - stall=1 freezes nxt_instr, all RAS entries, count and pointer.
  - No push, pop or underflow occurs during a stall.
  - ras_underflow is 0 during a stalled cycle.
- RAS organisation: circular LIFO.
  - Push writes at top+1 and increments top (mod RAS_DEPTH).
  - Pop reads top and decrements top.
  - Count saturates at RAS_DEPTH. A push when full overwrites the oldest entry, so the newest RAS_DEPTH return addresses survive. ras_full stays 1.
- push_ra with pc_sel other than 10 is ignored. pc_sel=11 never pushes.
- Flags ras_empty and ras_full are combinational from the count and change only after the edge that updates it.
- Reset mid-operation (any phase of clk) discards the RAS contents and the pending update.

Decomposition:
- Shared package pc_pkg holds:
  - the pc_sel encodings PC_SEL_SEQ, PC_SEL_BR, PC_SEL_JMP, PC_SEL_RET
  - a function for sign-extending imm to PC_WIDTH.
- One sub-module, ras_stack, parametrised by PC_WIDTH and RAS_DEPTH:
  - inputs: push, pop, push data
  - outputs: top data, empty, full
  - owns the entry array, pointer and count.
- pc_unit owns the PC register, next-PC mux, stall gating and underflow pulse.

Test Plan (defaults: PC_WIDTH=16, IMM_WIDTH=7, RAS_DEPTH=4, RESET_VECTOR=0):
1. Reset and sequential stepping.
   - rst_n=0 mid-cycle → nxt_instr=0x0000 immediately, ras_empty=1.
   - Release reset, pc_sel=00 for two edges → 0x0001, then 0x0002.
2. Branch and wrap-around.
   - From 0x0002, pc_sel=01, imm=7'b1111110 → 0x0001.
   - pc_sel=10, alu_out=0xFFFF → 0xFFFF; then pc_sel=00 → 0x0000.
3. Call and return.
   - At 0x0010, pc_sel=10, push_ra=1, alu_out=0xABCD → 0xABCD, ras_empty=0.
   - pc_sel=00 → 0xABCE.
   - pc_sel=11 → 0x0011, ras_empty=1.
4. Overflow and underflow.
   - Five calls from PCs 0x0100, 0x0200, 0x0300, 0x0400, 0x0500 → ras_full=1.
   - Four returns → 0x0501, 0x0401, 0x0301, 0x0201.
   - Fifth return → pc1 and ras_underflow=1 for one cycle only.
5. Stall.
   - stall=1 with pc_sel=10, push_ra=1, alu_out=0x1234 for 3 edges → nxt_instr and RAS flags unchanged.
   - stall=0 → 0x1234 and one push recorded.
6. Ignored push and mid-stack reset.
   - push_ra=1 with pc_sel=01 → ras_empty stays 1.
   - With 2 entries pushed, pulse rst_n=0 between edges → nxt_instr=0x0000, ras_empty=1.
   - A subsequent return underflows.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the RiSC-16 program-counter unit.
//   - pc_sel encodings (sequential, branch, jump, return)
//   - sext32: sign-extends the low `width` bits of a value to 32 bits;
//     callers truncate the result to their own address width.
package pc_pkg;

    localparam logic [1:0] PC_SEL_SEQ = 2'b00;
    localparam logic [1:0] PC_SEL_BR  = 2'b01;
    localparam logic [1:0] PC_SEL_JMP = 2'b10;
    localparam logic [1:0] PC_SEL_RET = 2'b11;

    // width must be in 1..32. Bits at or above width are replaced with the
    // sign bit val[width-1].
    function automatic logic [31:0] sext32(input logic [31:0] val, input int unsigned width);
        logic [31:0] res;
        logic        sign;
        sign = val[5'(width - 1)];
        res  = val;
        for (int i = 0; i < 32; i++) begin
            if (i >= int'(width)) begin
                res[i] = sign;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack (LIFO).
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data at top+1 and advance top
//   pop        : retreat top (ignored when empty); push has priority
//   push_data  : return address to store
//   top_data   : entry currently at top
//   empty/full : count is zero / count is RAS_DEPTH
// Count saturates at RAS_DEPTH; pushing when full overwrites the oldest
// entry because the pointer simply wraps onto it.
module ras_stack
    import pc_pkg::*;
#(
    parameter int unsigned PC_WIDTH  = 16,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic                pop,
    input  logic [PC_WIDTH-1:0] push_data,
    output logic [PC_WIDTH-1:0] top_data,
    output logic                empty,
    output logic                full
);

    localparam int unsigned PtrW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(RAS_DEPTH);

    logic [PC_WIDTH-1:0] entries [RAS_DEPTH];
    logic [PtrW-1:0]     top_q, top_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                wr_en;

    always_comb begin
        top_d = top_q;
        cnt_d = cnt_q;
        wr_en = 1'b0;
        if (push) begin
            top_d = top_q + PtrW'(1);
            wr_en = 1'b1;
            if (cnt_q != FullCnt) begin
                cnt_d = cnt_q + CntW'(1);
            end
        end else if (pop && (cnt_q != '0)) begin
            top_d = top_q - PtrW'(1);
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_q <= '0;
            cnt_q <= '0;
        end else begin
            top_q <= top_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry contents are don't-care after reset, so no reset on the array.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            entries[top_d] <= push_data;
        end
    end

    assign top_data = entries[top_q];
    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == FullCnt);

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit for the RiSC-16 fetch stage.
//   clk, rst_n    : clock, asynchronous active-low reset
//   stall         : hold PC and RAS this cycle
//   pc_sel        : 00 seq, 01 branch, 10 jump, 11 return
//   imm           : signed branch offset
//   alu_out       : jump target
//   push_ra       : push PC+1 on a jump (call)
//   nxt_instr     : registered fetch address
//   ras_empty     : RAS holds no entries
//   ras_full      : RAS holds RAS_DEPTH entries
//   ras_underflow : one-cycle pulse after a return found the RAS empty
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned          PC_WIDTH     = 16,
    parameter int unsigned          IMM_WIDTH    = 7,
    parameter int unsigned          RAS_DEPTH    = 4,
    parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic [1:0]           pc_sel,
    input  logic [IMM_WIDTH-1:0] imm,
    input  logic [PC_WIDTH-1:0]  alu_out,
    input  logic                 push_ra,
    output logic [PC_WIDTH-1:0]  nxt_instr,
    output logic                 ras_empty,
    output logic                 ras_full,
    output logic                 ras_underflow
);

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                uf_q, uf_d;
    logic [PC_WIDTH-1:0] pc1;
    logic [PC_WIDTH-1:0] br_off;
    logic [31:0]         imm_ext;
    logic [PC_WIDTH-1:0] ras_top;
    logic                ras_push, ras_pop;

    assign pc1     = pc_q + PC_WIDTH'(1);
    assign imm_ext = sext32(32'(imm), IMM_WIDTH);
    assign br_off  = imm_ext[PC_WIDTH-1:0];

    always_comb begin
        pc_d     = pc_q;
        uf_d     = 1'b0;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        if (!stall) begin
            unique case (pc_sel)
                PC_SEL_SEQ: pc_d = pc1;
                PC_SEL_BR:  pc_d = pc1 + br_off;
                PC_SEL_JMP: begin
                    pc_d     = alu_out;
                    ras_push = push_ra;
                end
                PC_SEL_RET: begin
                    if (ras_empty) begin
                        pc_d = pc1;
                        uf_d = 1'b1;
                    end else begin
                        pc_d    = ras_top;
                        ras_pop = 1'b1;
                    end
                end
                default: pc_d = pc1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_VECTOR;
            uf_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            uf_q <= uf_d;
        end
    end

    ras_stack #(
        .PC_WIDTH  (PC_WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc1),
        .top_data  (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    assign nxt_instr     = pc_q;
    assign ras_underflow = uf_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed plan steps followed by random
// traffic, all checked against a queue-based behavioural model.
module tb_pc_unit;

    localparam int unsigned PcW   = 16;
    localparam int unsigned ImmW  = 7;
    localparam int unsigned Depth = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            stall = 1'b0;
    logic [1:0]      pc_sel = 2'b00;
    logic [ImmW-1:0] imm = '0;
    logic [PcW-1:0]  alu_out = '0;
    logic            push_ra = 1'b0;
    logic [PcW-1:0]  nxt_instr;
    logic            ras_empty, ras_full, ras_underflow;

    pc_unit #(
        .PC_WIDTH     (PcW),
        .IMM_WIDTH    (ImmW),
        .RAS_DEPTH    (Depth),
        .RESET_VECTOR (16'h0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .pc_sel        (pc_sel),
        .imm           (imm),
        .alu_out       (alu_out),
        .push_ra       (push_ra),
        .nxt_instr     (nxt_instr),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full),
        .ras_underflow (ras_underflow)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [PcW-1:0] m_pc;
    logic [PcW-1:0] m_ras [$];
    logic           m_uf;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, " pc"}, 32'(nxt_instr), 32'(m_pc));
        check_eq({tag, " empty"}, 32'(ras_empty), 32'(m_ras.size() == 0));
        check_eq({tag, " full"}, 32'(ras_full), 32'(m_ras.size() == Depth));
        check_eq({tag, " uf"}, 32'(ras_underflow), 32'(m_uf));
    endtask

    // Drive one cycle's inputs, clock it, advance the model, then check.
    task automatic step(input string tag, input logic st, input logic [1:0] sel,
                        input logic [ImmW-1:0] im, input logic [PcW-1:0] alu, input logic pr);
        logic [PcW-1:0] pc1;
        stall   = st;
        pc_sel  = sel;
        imm     = im;
        alu_out = alu;
        push_ra = pr;
        @(posedge clk);
        pc1  = m_pc + 16'd1;
        m_uf = 1'b0;
        if (!st) begin
            case (sel)
                2'd0: m_pc = pc1;
                2'd1: m_pc = pc1 + 16'($signed(im));
                2'd2: begin
                    if (pr) begin
                        m_ras.push_back(pc1);
                        if (m_ras.size() > Depth) void'(m_ras.pop_front());
                    end
                    m_pc = alu;
                end
                default: begin
                    if (m_ras.size() > 0) begin
                        m_pc = m_ras.pop_back();
                    end else begin
                        m_pc = pc1;
                        m_uf = 1'b1;
                    end
                end
            endcase
        end
        #1;
        check_all(tag);
    endtask

    // Pulse reset between clock edges and check the asynchronous effect.
    task automatic pulse_reset(input string tag);
        #3;
        rst_n = 1'b0;
        #1;
        m_pc = 16'h0000;
        m_ras.delete();
        m_uf = 1'b0;
        check_all(tag);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        m_pc = 'x;
        m_uf = 1'b0;
        @(posedge clk);
        #1;
        pulse_reset("reset");

        // 1. sequential stepping
        step("seq1", 1'b0, 2'd0, '0, '0, 1'b0);
        step("seq2", 1'b0, 2'd0, '0, '0, 1'b0);
        // 2. negative branch, jump to top of memory, wrap
        step("br_neg", 1'b0, 2'd1, 7'b1111110, '0, 1'b0);
        step("jmp_ffff", 1'b0, 2'd2, '0, 16'hFFFF, 1'b0);
        step("wrap", 1'b0, 2'd0, '0, '0, 1'b0);
        // 3. call / return
        step("to_0010", 1'b0, 2'd2, '0, 16'h0010, 1'b0);
        step("call", 1'b0, 2'd2, '0, 16'hABCD, 1'b1);
        step("callee", 1'b0, 2'd0, '0, '0, 1'b0);
        step("ret", 1'b0, 2'd3, '0, '0, 1'b0);
        // 4. overflow then underflow
        step("to_0100", 1'b0, 2'd2, '0, 16'h0100, 1'b0);
        for (int i = 2; i <= 6; i++) begin
            step("call_n", 1'b0, 2'd2, '0, 16'(i * 256), 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            step("ret_n", 1'b0, 2'd3, '0, '0, 1'b0);
        end
        step("ret_uf", 1'b0, 2'd3, '0, '0, 1'b0);
        step("uf_clear", 1'b0, 2'd0, '0, '0, 1'b0);
        // 5. stall holds everything
        for (int i = 0; i < 3; i++) begin
            step("stall", 1'b1, 2'd2, '0, 16'h1234, 1'b1);
        end
        step("unstall", 1'b0, 2'd2, '0, 16'h1234, 1'b1);
        step("ret_after_stall", 1'b0, 2'd3, '0, '0, 1'b0);
        // 6. ignored push, mid-stack reset, underflow after reset
        step("br_push", 1'b0, 2'd1, 7'd5, 16'h5555, 1'b1);
        step("call_a", 1'b0, 2'd2, '0, 16'h0400, 1'b1);
        step("call_b", 1'b0, 2'd2, '0, 16'h0800, 1'b1);
        pulse_reset("mid_reset");
        step("ret_post_reset", 1'b0, 2'd3, '0, '0, 1'b0);

        // Random traffic; stall is never asserted right after an underflow
        // so the pulse is always observed for its full cycle.
        for (int n = 0; n < 400; n++) begin
            logic st;
            st = (($urandom_range(0, 4) == 0) && !m_uf);
            step("rand", st, 2'($urandom_range(0, 3)), 7'($urandom),
                 16'($urandom), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 99) == 0) begin
                pulse_reset("rand_reset");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
